serial_bus_master_port: RTL and testbench
=========================================

# serial_bus_master_port

Initiator end of the bit-serial system bus. The port accepts one parallel read or write request from a local master, serialises mode, address and write data onto `wr_bus` under a valid/ready handshake, and deserialises read data returned on `rd_bus`. It then returns a single-cycle response to the local master. It sits between a local master (CPU/UART/test controller) and the bus arbiter/slave bridges, and is the counterpart of the slave-side serial bridge.

## Interface
- `ADDR_WIDTH`, default 16: address bits per transaction.
- `DATA_WIDTH`, default 8: data bits per transaction.
- `TIMEOUT`, default 255: maximum consecutive stall cycles before abort; 0 disables the timeout.
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `req_valid`: input, 1 bit. Local request present.
- `req_ready`: output, 1 bit. The port accepts a request.
- `req_mode`: input, 1 bit. 1 = write, 0 = read.
- `req_addr`: input, `ADDR_WIDTH` bits. Request address.
- `req_wdata`: input, `DATA_WIDTH` bits. Write data.
- `rsp_valid`: output, 1 bit. One-cycle completion pulse.
- `rsp_err`: output, 1 bit. Qualifies `rsp_valid`; 1 = timeout abort.
- `rsp_rdata`: output, `DATA_WIDTH` bits. Read data, valid with `rsp_valid`.
- `mode`: output, 1 bit. Transaction direction to the slave, held for the whole transaction.
- `wr_bus`: output, 1 bit. Serial address/data to the slave, MSB first.
- `master_valid`: output, 1 bit. Address/data bit present on `wr_bus`.
- `slave_ready`: input, 1 bit. The slave samples `wr_bus` this cycle.
- `rd_bus`: input, 1 bit. Serial read data from the slave, MSB first.
- `slave_valid`: input, 1 bit. Read-data bit present on `rd_bus`.
- `master_ready`: output, 1 bit. The port samples `rd_bus` this cycle.
- `split`: input, 1 bit. The slave has split the read; stall cycles are not counted.

## Operation
- The state machine has six states: IDLE, ADDR, WDATA, RWAIT, RDATA, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch addr, wdata and mode into shift registers, clear the bit counter and stall counter, and go to ADDR.
- ADDR:
  - `master_valid`=1 and `wr_bus`=current address MSB.
  - A bit transfers on each cycle with `master_valid`&&`slave_ready`: shift, and increment the counter.
  - After bit `ADDR_WIDTH-1` transfers, go to WDATA if mode=1, otherwise to RWAIT.
- WDATA:
  - Same rules as ADDR, using the data register; `DATA_WIDTH` bits.
  - After the last bit, go to RESP with `rsp_err`=0.
- RWAIT/RDATA:
  - `master_valid`=0 and `master_ready`=1.
  - A bit is captured on each cycle with `slave_valid`&&`master_ready`: `rdata` = {`rdata[DATA_WIDTH-2:0]`, `rd_bus`}.
  - The first captured bit moves RWAIT to RDATA.
  - After `DATA_WIDTH` captured bits, go to RESP with `rsp_rdata`=the assembled byte.
- RESP: `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- Bit counter: width is `$clog2(ADDR_WIDTH+DATA_WIDTH)`; it resets to 0 on entry to ADDR, WDATA and RWAIT.
- Stall counter:
  - Increments on each cycle in ADDR/WDATA without `slave_ready`, and on each cycle in RWAIT/RDATA without `slave_valid` and without `split`.
  - Clears on any transfer.
  - When it reaches `TIMEOUT` (nonzero), go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- `split` high in RWAIT/RDATA: the port holds state with `master_ready`=1 indefinitely.
- `slave_ready` dropping mid-address or mid-data: no bit advances, and `wr_bus` holds the current bit.
- `req_valid` while not IDLE: ignored, because `req_ready`=0; no queuing.
- Output source: all bus-side outputs are registered or decoded from state only, with no combinational path from bus inputs.

## Timing
- Reset (asynchronous, immediate on `rst`=1):
  - State=IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mode`=0, `wr_bus`=0, `master_valid`=0, `master_ready`=0.
- Reset mid-transaction: the transaction is dropped with no response, and the bus outputs go idle in the same cycle.
- Accept at edge T: the first address bit is on `wr_bus` with `master_valid`=1 during cycle T+1.
- Write latency with `slave_ready` held high:
  - Bits occupy cycles T+1..T+`ADDR_WIDTH`+`DATA_WIDTH`.
  - `rsp_valid` is asserted in cycle T+`ADDR_WIDTH`+`DATA_WIDTH`+1, which is T+25 for 16/8.
  - `req_ready` returns in the following cycle.
- Read: `master_ready` rises in the cycle after the last address bit. `rsp_valid` is asserted in the cycle after the `DATA_WIDTH`th captured bit.
- `mode` is stable from cycle T+1 until the RESP cycle inclusive.

## Test plan
- Write, addr=0xA5C3, data=0x5E, `slave_ready`=1:
  - `wr_bus` sequence is 1010010111000011 then 01011110.
  - `master_valid` is high for 24 cycles.
  - `rsp_valid` is asserted at T+25 with `rsp_err`=0.
- Read, addr=0x0012; slave returns 0xC9 after 5 cycles:
  - 16 address bits are sent, then `master_ready`=1.
  - `rsp_rdata`=0xC9 and `rsp_err`=0.
- Write with `slave_ready` toggled 1,0,0,1,...:
  - The bit sequence is identical to the first test, with no bit dropped or duplicated.
  - Completion is delayed by exactly the number of low cycles.
- Read with `split`=1 for 1000 cycles, `TIMEOUT`=255, then the slave returns 0x3A: no abort, and `rsp_rdata`=0x3A.
- Read with the slave silent and `TIMEOUT`=8: `rsp_valid`=1 and `rsp_err`=1 eight stall cycles after the address completes, with `rsp_rdata`=0.
- Assert `rst` during bit 10 of a write:
  - `master_valid`=0, `wr_bus`=0 and `req_ready`=1 immediately.
  - No `rsp_valid` pulse.
  - The next request completes normally.

Source files
------------

// File: rtl/serial_bus_master_port_if.sv
// Local request/response and bit-serial bus signals of the initiator port.
// The master modport is the port's view; the slave modport is the far end.
interface serial_bus_master_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_mode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mode;
  logic                  wr_bus;
  logic                  master_valid;
  logic                  slave_ready;
  logic                  rd_bus;
  logic                  slave_valid;
  logic                  master_ready;
  logic                  split;

  modport master (
    input  req_valid, req_mode, req_addr, req_wdata,
    input  slave_ready, rd_bus, slave_valid, split,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mode, wr_bus, master_valid, master_ready
  );

  modport slave (
    output req_valid, req_mode, req_addr, req_wdata,
    output slave_ready, rd_bus, slave_valid, split,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mode, wr_bus, master_valid, master_ready
  );
endinterface

// File: rtl/serial_bus_master_port.sv
// Initiator end of the bit-serial bus: serialises mode/address/write data,
// deserialises read data and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a local request
// ADDR  | shifting address out on wr_bus, MSB first
// WDATA | shifting write data out on wr_bus, MSB first
// RWAIT | waiting for the first read-data bit
// RDATA | collecting the remaining read-data bits
// RESP  | one-cycle response to the local master
module serial_bus_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input logic                      clk,
  input logic                      rst,
  serial_bus_master_port_if.master bus
);
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH);
  localparam int SW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] TO_VAL    = SW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [CW-1:0]         bit_cnt;
  logic [SW-1:0]         stall_cnt;
  logic                  mode_r;
  logic                  rsp_err_r;
  logic                  in_wr, in_rd;
  logic                  wr_xfer, rd_xfer, stall, last_bit, timeout_hit;

  assign in_wr       = (state == ADDR) || (state == WDATA);
  assign in_rd       = (state == RWAIT) || (state == RDATA);
  assign wr_xfer     = in_wr && bus.slave_ready;
  assign rd_xfer     = in_rd && bus.slave_valid;
  assign stall       = (in_wr && !bus.slave_ready) ||
                       (in_rd && !bus.slave_valid && !bus.split);
  assign last_bit    = (state == ADDR) ? (bit_cnt == ADDR_LAST) : (bit_cnt == DATA_LAST);
  assign timeout_hit = (TIMEOUT != 0) && stall && ((stall_cnt + SW'(1)) == TO_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid) state_nxt = ADDR;
      ADDR:  if (wr_xfer && last_bit) state_nxt = mode_r ? WDATA : RWAIT;
      WDATA: if (wr_xfer && last_bit) state_nxt = RESP;
      RWAIT,
      RDATA: if (rd_xfer) state_nxt = last_bit ? RESP : RDATA;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = RESP;
  end

  // Bus-side outputs decode from state and registers only, never from bus inputs.
  assign bus.req_ready    = (state == IDLE);
  assign bus.master_valid = in_wr;
  assign bus.master_ready = in_rd;
  assign bus.wr_bus       = (state == ADDR)  ? addr_sh[ADDR_WIDTH-1] :
                            (state == WDATA) ? data_sh[DATA_WIDTH-1] : 1'b0;
  assign bus.mode         = mode_r && (state != IDLE);
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_err      = rsp_err_r;
  assign bus.rsp_rdata    = rsp_rdata_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_sh     <= '0;
      data_sh     <= '0;
      rdata_sh    <= '0;
      rsp_rdata_r <= '0;
      bit_cnt     <= '0;
      stall_cnt   <= '0;
      mode_r      <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        addr_sh     <= bus.req_addr;
        data_sh     <= bus.req_wdata;
        mode_r      <= bus.req_mode;
        bit_cnt     <= '0;
        stall_cnt   <= '0;
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= '0;
      end
      // Counter wraps to zero on the last bit so each phase starts fresh.
      if (wr_xfer || rd_xfer) begin
        stall_cnt <= '0;
        bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
      end else if (stall) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
      if (state == ADDR && wr_xfer)  addr_sh <= {addr_sh[ADDR_WIDTH-2:0], 1'b0};
      if (state == WDATA && wr_xfer) data_sh <= {data_sh[DATA_WIDTH-2:0], 1'b0};
      if (rd_xfer) begin
        rdata_sh <= {rdata_sh[DATA_WIDTH-2:0], bus.rd_bus};
        if (last_bit) rsp_rdata_r <= {rdata_sh[DATA_WIDTH-2:0], bus.rd_bus};
      end
      if (timeout_hit) begin
        rsp_err_r   <= 1'b1;
        rsp_rdata_r <= '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_bus_master_port.sv
// Bench for serial_bus_master_port: table vectors, randomized transactions
// against a cycle-count reference model, timeout and reset sequences.
module tb_serial_bus_master_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b  ();
  serial_bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b8 ();

  serial_bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .bus(b));
  serial_bus_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(b8));

  int n_chk  = 0;
  int n_fail = 0;

  // Per-cycle slave behaviour: rdy_pat indexed by cycle after accept (1..),
  // rv_pat/sp_pat indexed by cycles since master_ready first seen (0..).
  bit rdy_pat [4096];
  bit rv_pat  [4096];
  bit sp_pat  [4096];

  typedef struct {
    logic       m;
    logic [15:0] a;
    logic [7:0] d;
    logic [7:0] rv;
    int         rkind;
    int         rd_delay;
    int         split_len;
    int         exp_lat;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rkind: 0 always ready, 1 repeating 1,0,0,1, 2 random.
  // rv_rand: read bits arrive with random gaps and random split cycles.
  task automatic fill(input int rkind, input int rd_delay, input int split_len, input bit rv_rand);
    bit tog [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4096; k++) begin
      case (rkind)
        0: rdy_pat[k] = 1'b1;
        1: rdy_pat[k] = (k == 0) ? 1'b1 : tog[(k-1) % 4];
        default: rdy_pat[k] = ($urandom_range(0, 9) < 7);
      endcase
      if (k < split_len) begin
        rv_pat[k] = 1'b0; sp_pat[k] = 1'b1;
      end else if (k < split_len + rd_delay) begin
        rv_pat[k] = 1'b0; sp_pat[k] = 1'b0;
      end else if (rv_rand) begin
        rv_pat[k] = ($urandom_range(0, 9) < 6);
        sp_pat[k] = !rv_pat[k] && ($urandom_range(0, 9) < 3);
      end else begin
        rv_pat[k] = 1'b1; sp_pat[k] = 1'b0;
      end
    end
  endtask

  // Reference: count handshakes. 16 address bits (+8 data for writes) each need
  // one ready cycle; a read then needs 8 valid cycles; response one cycle later.
  function automatic void model(input logic m, output int lat, output int r_cyc);
    int ones = 0;
    int k = 1;
    int need = m ? 24 : 16;
    int i = 0;
    while (ones < need && k < 4000) begin
      if (rdy_pat[k]) ones++;
      k++;
    end
    if (m) begin
      lat = k; r_cyc = -1;
    end else begin
      r_cyc = k; ones = 0;
      while (ones < 8 && i < 4000) begin
        if (rv_pat[i]) ones++;
        i++;
      end
      lat = k + i;
    end
  endfunction

  task automatic run_txn(input logic m, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] rv, output int lat, output int r_seen,
                         output logic err, output logic [7:0] rdata,
                         output logic [23:0] bits, output int nbits, output logic mode_ok);
    int k = 1;
    int rcap = 0;
    int i;
    logic done = 1'b0;
    lat = -1; r_seen = -1; err = 1'bx; rdata = 'x; bits = '0; nbits = 0; mode_ok = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", b.req_ready, 1'b1);
    b.req_valid = 1'b1; b.req_mode = m; b.req_addr = a; b.req_wdata = d;
    @(negedge clk);
    while (!done && k < 3000) begin
      b.req_valid = $urandom_range(0, 1);
      b.req_mode  = $urandom_range(0, 1);
      b.req_addr  = 16'($urandom);
      b.req_wdata = 8'($urandom);
      b.slave_ready = rdy_pat[k];
      if (b.master_ready && r_seen < 0) r_seen = k;
      if (r_seen >= 0) begin
        i = k - r_seen;
        b.slave_valid = rv_pat[i];
        b.split       = sp_pat[i];
        b.rd_bus      = (rv_pat[i] && rcap < 8) ? rv[7 - rcap] : 1'($urandom_range(0, 1));
      end else begin
        b.slave_valid = 1'b0; b.split = 1'b0; b.rd_bus = 1'b0;
      end
      if (b.master_valid && b.slave_ready) begin
        bits = {bits[22:0], b.wr_bus};
        nbits++;
      end
      if (b.master_ready && b.slave_valid) rcap++;
      if (b.mode !== m) mode_ok = 1'b0;
      if (b.rsp_valid === 1'b1) begin
        done = 1'b1; lat = k; err = b.rsp_err; rdata = b.rsp_rdata;
        b.req_valid = 1'b0;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    b.req_valid = 1'b0; b.slave_valid = 1'b0; b.split = 1'b0;
    @(negedge clk);
    chk("req_ready_after", b.req_ready, 1'b1);
    chk("rsp_single_cycle", b.rsp_valid, 1'b0);
  endtask

  task automatic check_txn(input string tag, input logic m, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] rv, input int exp_lat);
    int lat, r_seen, nbits, m_lat, m_r;
    logic err, mode_ok;
    logic [7:0] rdata;
    logic [23:0] bits;
    model(m, m_lat, m_r);
    run_txn(m, a, d, rv, lat, r_seen, err, rdata, bits, nbits, mode_ok);
    chk({tag, "_lat"}, lat, (exp_lat >= 0) ? exp_lat : m_lat);
    chk({tag, "_nbits"}, nbits, m ? 24 : 16);
    chk({tag, "_bits"}, bits, m ? {a, d} : {8'h00, a});
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_mode"}, mode_ok, 1'b1);
    chk({tag, "_mready_cycle"}, r_seen, m_r);
    if (!m) chk({tag, "_rdata"}, rdata, rv);
  endtask

  task automatic run8(input logic m, input logic rdy, output int lat,
                      output logic err, output logic [7:0] rd);
    int k = 1;
    lat = -1; err = 1'bx; rd = 'x;
    @(negedge clk);
    b8.req_valid = 1'b1; b8.req_mode = m;
    b8.req_addr = 16'($urandom); b8.req_wdata = 8'($urandom);
    b8.slave_ready = rdy; b8.slave_valid = 1'b0; b8.split = 1'b0;
    @(negedge clk);
    b8.req_valid = 1'b0;
    while (lat < 0 && k < 200) begin
      if (b8.rsp_valid === 1'b1) begin
        lat = k; err = b8.rsp_err; rd = b8.rsp_rdata;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    chk("t8_req_ready_after", b8.req_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic err;
    logic [7:0] rd;
    bit seen;
    {b.req_valid, b.req_mode, b.slave_ready, b.rd_bus, b.slave_valid, b.split} = '0;
    b.req_addr = '0; b.req_wdata = '0;
    {b8.req_valid, b8.req_mode, b8.slave_ready, b8.rd_bus, b8.slave_valid, b8.split} = '0;
    b8.req_addr = '0; b8.req_wdata = '0;

    vt[0] = '{1'b1, 16'hA5C3, 8'h5E, 8'h00, 0, 0, 0, 25};
    vt[1] = '{1'b0, 16'h0012, 8'h00, 8'hC9, 0, 5, 0, 30};
    vt[2] = '{1'b1, 16'hA5C3, 8'h5E, 8'h00, 1, 0, 0, 49};
    vt[3] = '{1'b0, 16'h1234, 8'h00, 8'h3A, 0, 0, 1000, 1025};
    vt[4] = '{1'b0, 16'hFFFF, 8'h00, 8'h81, 0, 0, 0, 25};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", b.req_ready, 1'b1);
    chk("rst_rsp", {b.rsp_valid, b.rsp_err, b.rsp_rdata}, 10'h0);
    chk("rst_bus", {b.mode, b.wr_bus, b.master_valid, b.master_ready}, 4'h0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(vt[v].rkind, vt[v].rd_delay, vt[v].split_len, 1'b0);
      check_txn($sformatf("vec%0d", v), vt[v].m, vt[v].a, vt[v].d, vt[v].rv, vt[v].exp_lat);
    end

    for (int r = 0; r < 40; r++) begin
      logic rm;
      rm = $urandom_range(0, 1);
      fill($urandom_range(0, 2), $urandom_range(0, 6),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : 0, 1'b1);
      check_txn($sformatf("rnd%0d", r), rm, 16'($urandom), 8'($urandom), 8'($urandom), -1);
    end

    // Silent slave after the address: 8 stall cycles then an error response.
    run8(1'b0, 1'b1, lat, err, rd);
    chk("t8_read_lat", lat, 25);
    chk("t8_read_err", err, 1'b1);
    chk("t8_read_rdata", rd, 8'h00);
    run8(1'b1, 1'b0, lat, err, rd);
    chk("t8_addr_lat", lat, 9);
    chk("t8_addr_err", err, 1'b1);

    // Reset while bit 10 of a write is on the bus.
    fill(0, 0, 0, 1'b0);
    @(negedge clk);
    b.slave_ready = 1'b1;
    b.req_valid = 1'b1; b.req_mode = 1'b1; b.req_addr = 16'hA5C3; b.req_wdata = 8'h5E;
    @(negedge clk);
    b.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("rstmid_busy", b.master_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_mvalid", b.master_valid, 1'b0);
    chk("rstmid_wr_bus", b.wr_bus, 1'b0);
    chk("rstmid_req_ready", b.req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (b.rsp_valid === 1'b1) seen = 1'b1;
    end
    chk("rstmid_no_rsp", seen, 1'b0);
    fill(0, 0, 0, 1'b0);
    check_txn("post_rst", 1'b1, 16'hA5C3, 8'h5E, 8'h00, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
